// File: rtl/alu_arbiter_pkg.sv
// Shared types and helpers for the two-requester ALU arbiter: FSM encoding,
// opcode constants, the add/subtract opcode set and result-flag derivation.
package alu_arbiter_pkg;

    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Opcodes that select addition; every other opcode subtracts.
    localparam logic [3:0] OP_ADD_0 = 4'b0000;
    localparam logic [3:0] OP_ADD_4 = 4'b0100;
    localparam logic [3:0] OP_ADD_6 = 4'b0110;
    localparam logic [3:0] OP_ADD_8 = 4'b1000;
    localparam logic [3:0] OP_ADD_9 = 4'b1001;
    localparam logic [3:0] OP_ADD_A = 4'b1010;
    localparam logic [3:0] OP_ADD_B = 4'b1011;
    localparam logic [3:0] OP_SUB   = 4'b0001;

    typedef struct packed {
        logic zero;
        logic pos;
    } flags_t;

    function automatic logic is_add(input logic [3:0] op);
        logic add;
        case (op)
            OP_ADD_0, OP_ADD_4, OP_ADD_6, OP_ADD_8,
            OP_ADD_9, OP_ADD_A, OP_ADD_B: add = 1'b1;
            default:                      add = 1'b0;
        endcase
        return add;
    endfunction

    function automatic flags_t derive_flags(input logic [DATA_W-1:0] r);
        flags_t f;
        f.zero = (r == '0);
        f.pos  = ~r[DATA_W-1] & (r != '0);
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_component: combinational 16-bit add/subtract unit with its own flags.
// Arithmetic wraps modulo 2^16; carry and borrow are dropped.
module alu_component
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] in0_i,
    input  logic [DATA_W-1:0] in1_i,
    output logic [DATA_W-1:0] out_o,
    output logic              zero_o,
    output logic              pos_o
);
    flags_t flags;

    always_comb begin
        out_o = is_add(op_i) ? (in0_i + in1_i) : (in0_i - in1_i);
    end

    assign flags  = derive_flags(out_o);
    assign zero_o = flags.zero;
    assign pos_o  = flags.pos;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of the shared ALU: grant, execute, hold result until ack.
// Define ALU_ARBITER_RR_EN for round-robin tie breaking; default is fixed priority to requester 0.
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  op0,
    input  logic [3:0]  op1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic [1:0]  ack,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        busy,
    output logic [15:0] result,
    output logic        zero,
    output logic        pos
);
    state_e      state_q;
    logic        owner_q;
    logic        last_owner_q;
    logic [3:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [1:0]  gnt_q;
    logic [1:0]  done_q;
    logic [15:0] result_q;
    logic        zero_q;
    logic        pos_q;

    logic        win_valid_d;
    logic        win_d;
    logic [1:0]  win_mask_d;
    logic [3:0]  op_d;
    logic [15:0] a_d;
    logic [15:0] b_d;
    logic [15:0] alu_out;
    flags_t      alu_flags;

    always_comb begin
        win_valid_d = req0 | req1;
        win_d       = 1'b0;
        if (req0 && req1) begin
`ifdef ALU_ARBITER_RR_EN
            win_d = ~last_owner_q;
`else
            win_d = 1'b0;
`endif
        end else if (req1) begin
            win_d = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_win_mask
            assign win_mask_d[gi] = (win_d == 1'(gi));
        end
    endgenerate

    assign op_d = win_d ? op1 : op0;
    assign a_d  = win_d ? a1  : a0;
    assign b_d  = win_d ? b1  : b0;

    // The ALU's own flags are unused; flags come from the registered result.
    alu_component u_alu (
        .op_i   (op_q),
        .in0_i  (a_q),
        .in1_i  (b_q),
        .out_o  (alu_out),
        .zero_o (),
        .pos_o  ()
    );

    assign alu_flags = derive_flags(alu_out);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            pos_q        <= 1'b0;
        end else begin
            gnt_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (win_valid_d) begin
                        owner_q      <= win_d;
                        last_owner_q <= win_d;
                        op_q         <= op_d;
                        a_q          <= a_d;
                        b_q          <= b_d;
                        gnt_q        <= win_mask_d;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_out;
                    zero_q   <= alu_flags.zero;
                    pos_q    <= alu_flags.pos;
                    done_q   <= owner_q ? 2'b10 : 2'b01;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    // Only the owner's ack bit releases the result.
                    if (ack[owner_q]) begin
                        done_q  <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign busy   = (state_q != ST_IDLE);
    assign result = result_q;
    assign zero   = zero_q;
    assign pos    = pos_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_alu_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic [1:0]  ack;
    logic [1:0]  gnt, done;
    logic        busy;
    logic [15:0] result;
    logic        zero, pos;

    int vectors = 0;
    int miscompares = 0;

    alu_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .op0    (op0),
        .op1    (op1),
        .a0     (a0),
        .b0     (b0),
        .a1     (a1),
        .b1     (b1),
        .ack    (ack),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .result (result),
        .zero   (zero),
        .pos    (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [31:0] s;
        if (op inside {4'd0, 4'd4, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11})
            s = 32'(a) + 32'(b);
        else
            s = 32'(a) + 32'h10000 - 32'(b);
        return s[15:0];
    endfunction

    // Transaction-level reference: an operation is granted, computed a cycle later,
    // and retired by its owner's ack.
    bit          m_active = 1'b0;
    int          m_age = 0;
    bit          m_owner = 1'b0;
    bit          m_last = 1'b1;
    logic [15:0] m_pend = '0;
    logic [15:0] m_res = '0;
    bit          m_zero = 1'b0;
    bit          m_pos = 1'b0;
    logic [1:0]  m_gnt = '0;
    logic [1:0]  m_done = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_last   = 1'b1;
            m_res    = '0;
            m_zero   = 1'b0;
            m_pos    = 1'b0;
            m_gnt    = '0;
            m_done   = '0;
        end else begin
            m_gnt = '0;
            if (!m_active) begin
                if (req0 || req1) begin
                    if (req0 && req1) begin
`ifdef ALU_ARBITER_RR_EN
                        m_owner = !m_last;
`else
                        m_owner = 1'b0;
`endif
                    end else begin
                        m_owner = req1;
                    end
                    m_last   = m_owner;
                    m_active = 1'b1;
                    m_age    = 1;
                    m_gnt    = 2'b01 << m_owner;
                    m_pend   = m_owner ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
                end
            end else if (m_age == 1) begin
                m_age  = 2;
                m_res  = m_pend;
                m_zero = (m_res == 16'd0);
                m_pos  = ($signed(m_res) > 0);
                m_done = 2'b01 << m_owner;
            end else if (ack[m_owner]) begin
                m_active = 1'b0;
                m_done   = '0;
            end
        end
        #1;
        check("gnt", gnt, m_gnt);
        check("done", done, m_done);
        check("busy", busy, m_active);
        check("result", result, m_res);
        check("zero", zero, m_zero);
        check("pos", pos, m_pos);
        check("gnt_onehot", ($countones(gnt) <= 1), 1);
        check("done_onehot", ($countones(done) <= 1), 1);
        check("gnt_done_excl", ((gnt != 0) && (done != 0)), 0);
    end

    task automatic set_req(input int idx, input logic v, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b);
        if (idx == 0) begin
            req0 = v; op0 = op; a0 = a; b0 = b;
        end else begin
            req1 = v; op1 = op; a1 = a; b1 = b;
        end
    endtask

    task automatic wait_gnt(output logic [1:0] g);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 2'b00 && n < 10);
        g = gnt;
        if (gnt == 2'b00) check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done == 2'b00 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (done == 2'b00) check("done_timeout", 0, 1);
    endtask

    task automatic do_op(input int idx, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] er, input logic ez,
                         input logic ep, input int hold, input bit wrong_ack);
        logic [1:0] g;
        logic [1:0] mask;
        mask = (idx == 0) ? 2'b01 : 2'b10;
        @(negedge clk);
        set_req(idx, 1'b1, op, a, b);
        wait_gnt(g);
        check("lit_gnt", g, mask);
        set_req(idx, 1'b0, op, a, b);
        @(negedge clk);
        wait_done();
        check("lit_done", done, mask);
        check("lit_result", result, er);
        check("lit_zero", zero, ez);
        check("lit_pos", pos, ep);
        if (wrong_ack) begin
            ack = ~mask;
            @(negedge clk);
            ack = 2'b00;
            check("lit_wrong_ack_done", done, mask);
        end
        repeat (hold) @(negedge clk);
        check("lit_done_held", done, mask);
        ack = mask;
        @(negedge clk);
        ack = 2'b00;
        check("lit_idle_busy", busy, 0);
        check("lit_idle_done", done, 0);
    endtask

    logic [1:0] g;
    int         exp_win[3];

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        ack = 2'b00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("lit_rst_gnt", gnt, 0);
        check("lit_rst_done", done, 0);
        check("lit_rst_busy", busy, 0);
        check("lit_rst_result", result, 0);
        check("lit_rst_flags", {zero, pos}, 0);

        do_op(0, 4'b0000, 16'd5, 16'd3, 16'd8, 1'b0, 1'b1, 3, 1'b1);
        do_op(1, 4'b0001, 16'd3, 16'd5, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
        do_op(1, 4'b0001, 16'd7, 16'd7, 16'h0000, 1'b1, 1'b0, 1, 1'b0);

        // Ack while idle must change nothing.
        @(negedge clk);
        ack = 2'b11;
        @(negedge clk);
        ack = 2'b00;
        @(negedge clk);
        check("lit_idle_ack_busy", busy, 0);
        check("lit_idle_ack_result", result, 16'h0000);
        check("lit_idle_ack_zero", zero, 1);

        // Tie: last owner is requester 1 here.
`ifdef ALU_ARBITER_RR_EN
        exp_win = '{0, 1, 0};
`else
        exp_win = '{0, 0, 0};
`endif
        set_req(0, 1'b1, 4'b0000, 16'hFFFF, 16'd1);
        set_req(1, 1'b1, 4'b0000, 16'hFFFF, 16'd1);
        for (int k = 0; k < 3; k++) begin
            wait_gnt(g);
            check("lit_tie_winner", g, (exp_win[k] == 0) ? 2'b01 : 2'b10);
            if (g[1]) req1 = 1'b0; else req0 = 1'b0;
            @(negedge clk);
            wait_done();
            check("lit_tie_result", result, 16'h0000);
            check("lit_tie_zero", zero, 1);
            ack = done;
            @(negedge clk);
            ack = 2'b00;
            if (k < 2) begin
                if (g[1]) req1 = 1'b1; else req0 = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset during EXEC after a nonzero result is held.
        do_op(0, 4'b0000, 16'd5, 16'd3, 16'd8, 1'b0, 1'b1, 0, 1'b0);
        @(negedge clk);
        set_req(0, 1'b1, 4'b0100, 16'd10, 16'd20);
        wait_gnt(g);
        reset = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("lit_rexec_done", done, 0);
        check("lit_rexec_busy", busy, 0);
        check("lit_rexec_result", result, 0);
        check("lit_rexec_flags", {zero, pos}, 0);
        repeat (3) @(negedge clk);
        check("lit_rexec_nognt", gnt, 0);

        // Reset during DONE.
        set_req(1, 1'b1, 4'b1000, 16'd100, 16'd1);
        wait_gnt(g);
        req1 = 1'b0;
        @(negedge clk);
        wait_done();
        check("lit_rdone_result_pre", result, 16'd101);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("lit_rdone_done", done, 0);
        check("lit_rdone_result", result, 0);
        check("lit_rdone_flags", {zero, pos}, 0);
        repeat (3) @(negedge clk);
        check("lit_rdone_nognt", gnt, 0);

        // Randomized traffic; the reference model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (req0) begin
                if (gnt[0]) req0 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                set_req(0, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom),
                        ($urandom_range(0, 5) == 0) ? a0 : 16'($urandom));
            end
            if (req1) begin
                if (gnt[1]) req1 = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                set_req(1, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom),
                        ($urandom_range(0, 5) == 0) ? a1 : 16'($urandom));
            end
            ack   = ($urandom_range(0, 1) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            reset = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; ack = 2'b00;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
